// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  // FSM encoding: 2-bit states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; counts 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_if.sv
// Valid-strobe operand/result bundle shared by the arithmetic units.
interface div_if #(
  parameter int unsigned N = 32
);
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         i_vld;
  logic [N-1:0] o_quot;
  logic [N-1:0] o_rem;
  logic         o_vld;
  logic         o_busy;

  modport master (
    output i_a, i_b, i_vld,
    input  o_quot, o_rem, o_vld, o_busy
  );

  modport slave (
    input  i_a, i_b, i_vld,
    output o_quot, o_rem, o_vld, o_busy
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on the remainder:quotient shift register.
module div_step #(
  parameter int unsigned N = 32
) (
  input  logic [2*N-1:0] rq,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] rq_next
);

  logic [N:0] t;
  // The partial remainder never exceeds N bits, so the top bit is always zero.
  logic       unused_msb;

  assign unused_msb = rq[2*N-1];

  // Trial subtract; keep the difference and shift in a 1 when it does not borrow.
  always_comb begin
    t = {1'b0, rq[2*N-2:N-1]} - {1'b0, divisor};
    if (!t[N]) begin
      rq_next = {t[N-1:0], rq[N-2:0], 1'b1};
    end else begin
      rq_next = {rq[2*N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, N+2 cycles per operation.
// Optional macro DIV_SIGNED_EN: two's-complement operands with sign fix-up on entry to DONE.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);

  localparam int unsigned      CNT_W    = cnt_w(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     divisor_q;
  logic [2*N-1:0]   rq_q, rq_next;
  logic [N-1:0]     quot_q, rem_q;
  logic [N-1:0]     a_mag, b_mag;
  logic [N-1:0]     quot_fix, rem_fix;
  logic             accept, last;

  assign accept = (state_q == IDLE) && bus.i_vld;
  assign last   = (state_q == STEP) && (cnt_q == CNT_LAST);

`ifdef DIV_SIGNED_EN
  logic a_neg_q, q_neg_q, b_zero_q;

  assign a_mag = bus.i_a[N-1] ? -bus.i_a : bus.i_a;
  assign b_mag = bus.i_b[N-1] ? -bus.i_b : bus.i_b;

  // Sign fix-up of the final iteration result; divide by zero is forced to -1 r a.
  always_comb begin
    quot_fix = q_neg_q ? -rq_next[N-1:0] : rq_next[N-1:0];
    if (b_zero_q) begin
      quot_fix = '1;
    end
    rem_fix = a_neg_q ? -rq_next[2*N-1:N] : rq_next[2*N-1:N];
  end

  // Operand sign information captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (accept) begin
      a_neg_q  <= bus.i_a[N-1];
      q_neg_q  <= bus.i_a[N-1] ^ bus.i_b[N-1];
      b_zero_q <= (bus.i_b == '0);
    end
  end
`else
  assign a_mag    = bus.i_a;
  assign b_mag    = bus.i_b;
  assign quot_fix = rq_next[N-1:0];
  assign rem_fix  = rq_next[2*N-1:N];
`endif

  div_step #(
    .N(N)
  ) u_step (
    .rq     (rq_q),
    .divisor(divisor_q),
    .rq_next(rq_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_vld) state_d = STEP;
      STEP:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand load on accept, one restoring step per STEP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      divisor_q <= '0;
      rq_q      <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      divisor_q <= b_mag;
      rq_q      <= {{N{1'b0}}, a_mag};
    end else if (state_q == STEP) begin
      cnt_q     <= cnt_q + CNT_W'(1);
      rq_q      <= rq_next;
    end
  end

  // Result registers, written on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
    end else if (last) begin
      quot_q <= quot_fix;
      rem_q  <= rem_fix;
    end
  end

  assign bus.o_quot = quot_q;
  assign bus.o_rem  = rem_q;
  assign bus.o_vld  = (state_q == DONE);
  assign bus.o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq at N=8; honours DIV_SIGNED_EN.
module tb_div_seq;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  div_if #(.N(N)) bus ();

  div_seq #(
    .N(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of the intended arithmetic.
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r);
`ifdef DIV_SIGNED_EN
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (a == 8'h80 && b == 8'hFF) begin
      q = 8'h80;
      r = 8'h00;
    end else begin
      q = N'($signed(a) / $signed(b));
      r = N'($signed(a) % $signed(b));
    end
`else
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // Issue one operation from IDLE; lat counts edges from the accept edge to o_vld seen high.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] q, output logic [N-1:0] r,
                       output int lat, output logic vld_after);
    @(negedge clk);
    bus.i_a   = a;
    bus.i_b   = b;
    bus.i_vld = 1'b1;
    @(posedge clk);
    #1 bus.i_vld = 1'b0;
    lat = 1;
    while (!bus.o_vld && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    q = bus.o_quot;
    r = bus.o_rem;
    @(posedge clk);
    #1 vld_after = bus.o_vld | bus.o_busy;
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } vec_t;

  vec_t vecs[$];
  logic [N-1:0] q, r, eq, er, a, b;
  int   lat, nvld;
  logic after;

  initial begin
    rst_n     = 1'b0;
    bus.i_a   = '0;
    bus.i_b   = '0;
    bus.i_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", bus.o_vld, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_quot", bus.o_quot, 0);
    check("rst_rem", bus.o_rem, 0);
    @(negedge clk) rst_n = 1'b1;

    // 100/7 with latency and pulse width.
    do_op(8'd100, 8'd7, q, r, lat, after);
    check("q_100_7", q, 14);
    check("r_100_7", r, 2);
    check("lat_100_7", lat, N + 1);
    check("vld_pulse", after, 0);

    vecs.push_back('{8'd255, 8'd1, 8'd255, 8'd0});
    vecs.push_back('{8'd3, 8'd10, 8'd0, 8'd3});
    vecs.push_back('{8'd200, 8'd200, 8'd1, 8'd0});
    vecs.push_back('{8'd5, 8'd0, 8'hFF, 8'd5});
    vecs.push_back('{8'hFB, 8'd0, 8'hFF, 8'hFB});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{8'hF9, 8'd2, 8'hFD, 8'hFF});
    vecs.push_back('{8'd7, 8'hFE, 8'hFD, 8'd1});
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'd0});
`else
    vecs.push_back('{8'hF9, 8'd2, 8'd124, 8'd1});
    vecs.push_back('{8'd7, 8'hFE, 8'd0, 8'd7});
    vecs.push_back('{8'h80, 8'hFF, 8'd0, 8'h80});
`endif
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, q, r, lat, after);
      check($sformatf("q_%0h_%0h", vecs[i].a, vecs[i].b), q, vecs[i].q);
      check($sformatf("r_%0h_%0h", vecs[i].a, vecs[i].b), r, vecs[i].r);
      check("lat_b2b", lat, N + 1);
    end

    // i_vld while busy is ignored.
    @(negedge clk);
    bus.i_a = 8'd100; bus.i_b = 8'd7; bus.i_vld = 1'b1;
    @(posedge clk);
    #1 bus.i_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.i_a = 8'd9; bus.i_b = 8'd2; bus.i_vld = 1'b1;
    @(posedge clk);
    #1 bus.i_vld = 1'b0;
    nvld = 0;
    q = '0; r = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_vld) begin
        nvld++;
        q = bus.o_quot;
        r = bus.o_rem;
      end
    end
    check("busy_nvld", nvld, 1);
    check("busy_q", q, 14);
    check("busy_r", r, 2);

    // Reset in the middle of STEP at cnt=3.
    @(negedge clk);
    bus.i_a = 8'd100; bus.i_b = 8'd7; bus.i_vld = 1'b1;
    @(posedge clk);
    #1 bus.i_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_rst_vld", bus.o_vld, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_quot", bus.o_quot, 0);
    check("mid_rst_rem", bus.o_rem, 0);
    @(negedge clk) rst_n = 1'b1;
    nvld = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (bus.o_vld) nvld++;
    end
    check("mid_rst_novld", nvld, 0);
    do_op(8'd50, 8'd6, q, r, lat, after);
    check("q_50_6", q, 8);
    check("r_50_6", r, 2);

    // Random vectors against the reference model.
    for (int i = 0; i < 200; i++) begin
      a = N'($urandom);
      b = (i % 16 == 0) ? '0 : N'($urandom_range(0, 255));
      ref_div(a, b, eq, er);
      do_op(a, b, q, r, lat, after);
      check($sformatf("rand_q_%0h_%0h", a, b), q, eq);
      check($sformatf("rand_r_%0h_%0h", a, b), r, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
